dnn_result_reader: RTL

Host-side controller for the DNN inference engine's control and output-select interface. It accepts a classify request and soft-resets the engine. It then pulses start, waits for done, and sweeps the ten class-score outputs through the engine's index select. Finally it returns the argmax class, its score and all ten scores over a valid/ready handshake, with a timeout guard against a hung engine.

---
 rtl/dnn_result_reader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dnn_result_reader.sv
// dnn_result_reader
// Host-side sequencer for the DNN inference engine. On a classify request it
// soft-resets the engine, pulses start, waits for done (with a timeout), sweeps
// all class scores through the engine's index select and returns the argmax.
//
// Ports
//   clk_i         : clock
//   rst_i         : synchronous active-high reset
//   req_valid_i   : classify request, accepted while req_ready_o is high
//   req_ready_o   : high only while idle
//   eng_reset_o   : one-cycle engine soft-reset pulse
//   eng_start_o   : one-cycle engine start pulse
//   eng_done_i    : engine completion level
//   eng_idx_o     : class index select to the engine (0 outside the sweep)
//   eng_out_i     : signed score of class eng_idx_o (combinational in the engine)
//   res_valid_o   : result available
//   res_ready_i   : consumer accepts result
//   res_class_o   : argmax class, 4'hF on timeout
//   res_score_o   : maximum score, 0 on timeout
//   res_scores_o  : all scores, class k at [k*DATA_WIDTH +: DATA_WIDTH]
//   res_timeout_o : result was produced by a timeout
module dnn_result_reader #(
    parameter int unsigned DATA_WIDTH     = 3,
    parameter int unsigned NUM_CLASSES    = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    output logic                                eng_reset_o,
    output logic                                eng_start_o,
    input  logic                                eng_done_i,
    output logic [3:0]                          eng_idx_o,
    input  logic signed [DATA_WIDTH-1:0]        eng_out_i,
    output logic                                res_valid_o,
    input  logic                                res_ready_i,
    output logic [3:0]                          res_class_o,
    output logic signed [DATA_WIDTH-1:0]        res_score_o,
    output logic [NUM_CLASSES*DATA_WIDTH-1:0]   res_scores_o,
    output logic                                res_timeout_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] IdxLast = 4'(NUM_CLASSES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStart,
        StWait,
        StSweep,
        StResult
    } state_e;

    state_e                             state_q;
    logic [CntW-1:0]                    wait_cnt_q;
    logic [3:0]                         idx_q;
    logic signed [DATA_WIDTH-1:0]       max_score_q;
    logic [3:0]                         max_class_q;
    logic [NUM_CLASSES*DATA_WIDTH-1:0]  scores_q;
    logic                               req_ready_q;
    logic                               eng_reset_q;
    logic                               eng_start_q;
    logic                               res_valid_q;
    logic                               timeout_q;

    // All outputs come straight from registers; the pulses and flags are set on
    // the edge that enters the corresponding state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            idx_q       <= '0;
            max_score_q <= '0;
            max_class_q <= '0;
            scores_q    <= '0;
            req_ready_q <= 1'b1;
            eng_reset_q <= 1'b0;
            eng_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            eng_reset_q <= 1'b0;
            eng_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        state_q     <= StClear;
                        req_ready_q <= 1'b0;
                        eng_reset_q <= 1'b1;
                    end
                end
                StClear: begin
                    wait_cnt_q  <= '0;
                    idx_q       <= '0;
                    scores_q    <= '0;
                    max_score_q <= '0;
                    max_class_q <= '0;
                    timeout_q   <= 1'b0;
                    eng_start_q <= 1'b1;
                    state_q     <= StStart;
                end
                StStart: begin
                    state_q <= StWait;
                end
                StWait: begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                    // Done takes priority over the terminal count.
                    if (eng_done_i) begin
                        state_q <= StSweep;
                    end else if (wait_cnt_q == CntLast) begin
                        state_q     <= StResult;
                        res_valid_q <= 1'b1;
                        timeout_q   <= 1'b1;
                        max_class_q <= 4'hF;
                        max_score_q <= '0;
                        scores_q    <= '0;
                    end
                end
                StSweep: begin
                    for (int k = 0; k < int'(NUM_CLASSES); k++) begin
                        if (idx_q == 4'(k)) begin
                            scores_q[k*DATA_WIDTH +: DATA_WIDTH] <= eng_out_i;
                        end
                    end
                    // Strict greater-than keeps the lowest index on ties.
                    if (idx_q == 4'd0 || eng_out_i > max_score_q) begin
                        max_score_q <= eng_out_i;
                        max_class_q <= idx_q;
                    end
                    if (idx_q == IdxLast) begin
                        idx_q       <= '0;
                        state_q     <= StResult;
                        res_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                StResult: begin
                    if (res_ready_i) begin
                        state_q     <= StIdle;
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign eng_reset_o   = eng_reset_q;
    assign eng_start_o   = eng_start_q;
    assign eng_idx_o     = idx_q;
    assign res_valid_o   = res_valid_q;
    assign res_class_o   = max_class_q;
    assign res_score_o   = max_score_q;
    assign res_scores_o  = scores_q;
    assign res_timeout_o = timeout_q;

endmodule
